// File: rtl/adc_sample_logger.sv
// ADC sample logger: paced conversions over a channel rotation, offset-corrected into a circular
// buffer, filled to FILL_LEVEL then drained one entry per step. Optional PEAK_TRACK_EN macro.
module adc_sample_logger #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned FILL_LEVEL = 30,
    parameter int unsigned SAMPLE_DIV = 50000000,
    parameter int unsigned OFFSET     = 3431,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned CH_BASE    = 17
) (
    input  logic                       clock_in,
    input  logic                       reset_n,
    output logic                       cmd_valid,
    output logic [4:0]                 cmd_channel,
    input  logic                       cmd_ready,
    input  logic                       rsp_valid,
    input  logic [4:0]                 rsp_channel,
    input  logic [DATA_W-1:0]          rsp_data,
    input  logic                       step,
    output logic [DATA_W-1:0]          out_data,
    output logic [4:0]                 out_channel,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     fill_count,
    output logic                       mode,
    output logic                       overflow
`ifdef PEAK_TRACK_EN
    ,
    output logic [DATA_W-1:0]          peak_min,
    output logic [DATA_W-1:0]          peak_max
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDrain} state_e;

    state_e              state_q, state_d;
    logic [31:0]         div_q, div_d;
    logic [ChW-1:0]      ch_idx_q, ch_idx_d;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     fill_q, fill_d;
    logic                step_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [4:0]          out_ch_q;
    logic                out_valid_q;
    logic                overflow_q, overflow_d;

    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [4:0]          mem_ch   [DEPTH];

    logic                tick;
    logic [4:0]          req_ch;
    logic                rsp_match;
    logic                wr_en;
    logic                pop;
    logic                drain_exit;
    logic [31:0]         raw_ext;
    logic [DATA_W-1:0]   wr_value;

    assign tick      = (div_q == 32'(SAMPLE_DIV - 1));
    assign req_ch    = 5'(CH_BASE) + 5'(ch_idx_q);
    assign rsp_match = rsp_valid && (rsp_channel == req_ch);
    assign wr_en     = (state_q == StRsp) && rsp_match;
    // step_q lags step by one cycle, so this is high only in the first cycle of a high level
    assign pop       = (state_q == StDrain) && step && !step_q;
    assign drain_exit = (state_q == StDrain) && (state_d == StIdle);

    // Saturate rather than wrap when the raw value is below the offset
    assign raw_ext  = 32'(rsp_data);
    assign wr_value = (raw_ext < OFFSET) ? '0 : DATA_W'(raw_ext - OFFSET);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        ch_idx_d   = ch_idx_q;
        overflow_d = overflow_q;
        cmd_valid  = 1'b0;
        fill_d     = fill_q;

        if (state_q != StDrain) begin
            div_d = tick ? 32'd0 : div_q + 32'd1;
        end

        case (state_q)
            StIdle: begin
                if (tick) state_d = StReq;
            end
            StReq: begin
                cmd_valid = 1'b1;
                if (tick) overflow_d = 1'b1;
                if (cmd_ready) state_d = StRsp;
            end
            StRsp: begin
                if (tick) overflow_d = 1'b1;
                if (rsp_match) begin
                    ch_idx_d = (ch_idx_q == ChW'(NUM_CH - 1)) ? '0 : ch_idx_q + 1'b1;
                    state_d  = (fill_q + 1'b1 == CntW'(FILL_LEVEL)) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (pop && fill_q == CntW'(1)) begin
                    state_d = StIdle;
                    div_d   = 32'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) fill_d = fill_q + 1'b1;
        else if (pop) fill_d = fill_q - 1'b1;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            ch_idx_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            step_q      <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ch_idx_q   <= ch_idx_d;
            fill_q     <= fill_d;
            step_q     <= step;
            overflow_q <= overflow_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                out_data_q  <= mem_data[rd_ptr_q];
                out_ch_q    <= mem_ch[rd_ptr_q];
                out_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= wr_value;
            mem_ch[wr_ptr_q]   <= rsp_channel;
        end
    end

`ifdef PEAK_TRACK_EN
    logic [DATA_W-1:0] peak_min_q, peak_max_q;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            peak_min_q <= '1;
            peak_max_q <= '0;
        end else if (drain_exit) begin
            peak_min_q <= '1;
            peak_max_q <= '0;
        end else if (wr_en) begin
            if (wr_value < peak_min_q) peak_min_q <= wr_value;
            if (wr_value > peak_max_q) peak_max_q <= wr_value;
        end
    end

    assign peak_min = peak_min_q;
    assign peak_max = peak_max_q;
`else
    logic unused_drain_exit;
    assign unused_drain_exit = drain_exit;
`endif

    assign cmd_channel = cmd_valid ? req_ch : 5'd0;
    assign out_data    = out_data_q;
    assign out_channel = out_ch_q;
    assign out_valid   = out_valid_q;
    assign fill_count  = fill_q;
    assign mode        = (state_q == StDrain);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_adc_sample_logger.sv
// Directed bench for adc_sample_logger: table-driven fill/drain plus hand-written overflow, step
// and reset sequences. Define PEAK_TRACK_EN to also cover the peak tracker.
module tb_adc_sample_logger;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic [4:0]        cmd_channel;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [4:0]        rsp_channel;
    logic [DATA_W-1:0] rsp_data;
    logic              step;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_channel;
    logic              out_valid;
    logic [3:0]        fill_count;
    logic              mode;
    logic              overflow;
`ifdef PEAK_TRACK_EN
    logic [DATA_W-1:0] peak_min;
    logic [DATA_W-1:0] peak_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    adc_sample_logger #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FILL_LEVEL(6),
        .SAMPLE_DIV(4),
        .OFFSET    (3431),
        .NUM_CH    (2),
        .CH_BASE   (16)
    ) dut (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_channel(cmd_channel),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_channel(rsp_channel),
        .rsp_data   (rsp_data),
        .step       (step),
        .out_data   (out_data),
        .out_channel(out_channel),
        .out_valid  (out_valid),
        .fill_count (fill_count),
        .mode       (mode),
        .overflow   (overflow)
`ifdef PEAK_TRACK_EN
        ,
        .peak_min   (peak_min),
        .peak_max   (peak_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int raw;
        int ch;
        int stored;
        bit wrong_first;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_valid) begin
                ok = 1'b1;
                return;
            end
            tick_clk();
        end
    endtask

    // One full conversion with cmd_ready already high; optional foreign response first.
    task automatic do_sample(input int raw, input int ch, input bit wrong, input bit step_too,
                             input int exp_fill);
        bit ok;
        wait_cmd(ok);
        check("cmd_valid seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("cmd_channel", 32'(cmd_channel), 32'(ch));
        tick_clk();
        if (wrong) begin
            rsp_valid   = 1'b1;
            rsp_channel = 5'd5;
            rsp_data    = 12'd3900;
            tick_clk();
            rsp_valid = 1'b0;
            check("foreign rsp ignored fill", 32'(fill_count), 32'(exp_fill - 1));
            check("foreign rsp no new cmd", 32'(cmd_valid), 32'd0);
        end
        rsp_valid   = 1'b1;
        rsp_channel = 5'(ch);
        rsp_data    = 12'(raw);
        if (step_too) step = 1'b1;
        tick_clk();
        rsp_valid = 1'b0;
        check("fill after write", 32'(fill_count), 32'(exp_fill));
        check("mode after write", 32'(mode), (exp_fill == 6) ? 32'd1 : 32'd0);
    endtask

    task automatic pop_one(input int exp_data, input int exp_ch, input int exp_fill);
        step = 1'b1;
        tick_clk();
        check("pop out_data", 32'(out_data), 32'(exp_data));
        check("pop out_channel", 32'(out_channel), 32'(exp_ch));
        check("pop fill_count", 32'(fill_count), 32'(exp_fill));
        check("pop out_valid", 32'(out_valid), 32'd1);
        step = 1'b0;
        tick_clk();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{raw: 3450, ch: 16, stored: 19,  wrong_first: 1'b0};
        vecs[1] = '{raw: 4000, ch: 17, stored: 569, wrong_first: 1'b1};
        vecs[2] = '{raw: 3400, ch: 16, stored: 0,   wrong_first: 1'b0};
        vecs[3] = '{raw: 3431, ch: 17, stored: 0,   wrong_first: 1'b0};
        vecs[4] = '{raw: 4095, ch: 16, stored: 664, wrong_first: 1'b0};
        vecs[5] = '{raw: 3432, ch: 17, stored: 1,   wrong_first: 1'b0};

        rst_n       = 1'b0;
        cmd_ready   = 1'b1;
        rsp_valid   = 1'b0;
        rsp_channel = '0;
        rsp_data    = '0;
        step        = 1'b0;
        repeat (3) tick_clk();
        check("reset cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset fill_count", 32'(fill_count), 32'd0);
        check("reset mode", 32'(mode), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Fill; a step raised alongside the last write lands before mode rises and must be ignored.
        for (int i = 0; i < 6; i++) begin
            do_sample(vecs[i].raw, vecs[i].ch, vecs[i].wrong_first, i == 5, i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            check("drain no cmd", 32'(cmd_valid), 32'd0);
            check("held step no pop", 32'(fill_count), 32'd6);
        end
        check("no pop before drain edge", 32'(out_valid), 32'd0);
        check("overflow clear in fill", 32'(overflow), 32'd0);
        step = 1'b0;
        tick_clk();

        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                // Held-high step pops only once
                step = 1'b1;
                tick_clk();
                tick_clk();
                check("long step one pop", 32'(fill_count), 32'd3);
                check("long step data", 32'(out_data), 32'(vecs[2].stored));
                step = 1'b0;
                tick_clk();
            end else begin
                pop_one(vecs[i].stored, vecs[i].ch, 5 - i);
            end
            if (i == 5) begin
                check("drain done mode", 32'(mode), 32'd0);
                cmd_ready = 1'b0;
            end
        end

        // Step edge in IDLE is ignored
        step = 1'b1;
        tick_clk();
        step = 1'b0;
        tick_clk();
        check("idle step data", 32'(out_data), 32'(vecs[5].stored));
        check("idle step fill", 32'(fill_count), 32'd0);

        // Sampling resumes; stall cmd_ready to force a dropped tick
        wait_cmd(ok);
        check("resume cmd_valid", 32'(ok), 32'd1);
        check("resume channel", 32'(cmd_channel), 32'd16);
        check("overflow before stall", 32'(overflow), 32'd0);
        repeat (10) tick_clk();
        check("stall overflow", 32'(overflow), 32'd1);
        check("stall cmd_valid held", 32'(cmd_valid), 32'd1);
        check("stall fill unchanged", 32'(fill_count), 32'd0);
        cmd_ready = 1'b1;
        tick_clk();
        check("accepted cmd drops", 32'(cmd_valid), 32'd0);
        rsp_valid   = 1'b1;
        rsp_channel = 5'd16;
        rsp_data    = 12'd3500;
        tick_clk();
        rsp_valid = 1'b0;
        check("post stall fill", 32'(fill_count), 32'd1);
        check("overflow sticky", 32'(overflow), 32'd1);
        tick_clk();
        check("overflow still sticky", 32'(overflow), 32'd1);

        // Asynchronous reset mid-run, checked before the next clock edge
        rst_n = 1'b0;
        #1;
        check("async rst fill", 32'(fill_count), 32'd0);
        check("async rst overflow", 32'(overflow), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_data", 32'(out_data), 32'd0);
        check("async rst out_channel", 32'(out_channel), 32'd0);
        check("async rst mode", 32'(mode), 32'd0);
        check("async rst cmd_valid", 32'(cmd_valid), 32'd0);
        check("async rst cmd_channel", 32'(cmd_channel), 32'd0);

`ifdef PEAK_TRACK_EN
        check("rst peak_min", 32'(peak_min), 32'd4095);
        check("rst peak_max", 32'(peak_max), 32'd0);
        tick_clk();
        rst_n = 1'b1;
        begin
            int pk[6];
            pk[0] = 5; pk[1] = 40; pk[2] = 2; pk[3] = 7; pk[4] = 7; pk[5] = 9;
            for (int i = 0; i < 6; i++) begin
                do_sample(3431 + pk[i], (i % 2 == 0) ? 16 : 17, 1'b0, 1'b0, i + 1);
            end
            check("peak_min filled", 32'(peak_min), 32'd2);
            check("peak_max filled", 32'(peak_max), 32'd40);
            for (int i = 0; i < 6; i++) begin
                pop_one(pk[i], (i % 2 == 0) ? 16 : 17, 5 - i);
            end
            check("peak_min after drain", 32'(peak_min), 32'd4095);
            check("peak_max after drain", 32'(peak_max), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
